alu_op_sequencer: RTL and testbench

- Multi-cycle ALU controller; sequences one shared WIDTH-bit add/sub unit to execute ADD, SUB, OR, NOR, MUL and DIV requests.
- Single-cycle ops finish in one EXEC cycle.
- MUL runs as iterative shift-add; DIV runs as restoring division.
- Sits between an operation issuer (valid/ready in) and a result consumer (valid/ready out), one operation in flight at a time.

---
 rtl/alu_op_sequencer_pkg.sv | 23 ++
 rtl/alu_op_sequencer_addsub.sv | 27 ++
 rtl/alu_op_sequencer.sv | 158 +++++++++++++++
 tb/tb_alu_op_sequencer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU operation sequencer: opcodes, FSM encodings
// and the default operand width.
package alu_op_sequencer_pkg;

  localparam int WIDTH_DEFAULT = 8;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_DIV = 3'b101;
  localparam logic [2:0] OP_ILLEGAL_MIN = 3'b110;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  function automatic logic is_illegal_op(input logic [2:0] op);
    return op >= OP_ILLEGAL_MIN;
  endfunction

endpackage

// File: rtl/alu_op_sequencer_addsub.sv
// Combinational ripple-carry adder/subtractor; sub inverts y and forces carry-in.
module alu_addsub #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0]   carry_chain;
  logic [WIDTH-1:0] y_eff;

  always_comb begin
    y_eff          = sub ? ~y : y;
    carry_chain    = '0;
    carry_chain[0] = sub;
    sum            = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i]           = x[i] ^ y_eff[i] ^ carry_chain[i];
      carry_chain[i+1] = (x[i] & y_eff[i]) | (carry_chain[i] & (x[i] ^ y_eff[i]));
    end
    cout = carry_chain[WIDTH];
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle ALU controller: one op in flight, single shared add/sub unit
// used for simple ops, shift-add multiply and restoring divide.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 carry,
  output logic                 div_by_zero,
  output logic                 illegal_op,
  output logic                 busy
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [1:0]         state;
  logic [2:0]         op_r;
  logic [WIDTH-1:0]   a_r, b_r;
  logic [2*WIDTH-1:0] acc, acc_next;
  logic [CW-1:0]      step;

  logic [WIDTH-1:0]   add_x, add_y, add_sum;
  logic               add_sub, add_cout;

  logic               iterative, last_step;
  logic [2*WIDTH-1:0] simple_result;
  logic               simple_carry, simple_dbz, simple_ill;

  assign iterative = (op_r == OP_MUL) || ((op_r == OP_DIV) && (b_r != '0));
  assign last_step = (step == CW'(WIDTH - 1));
  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);

  // MUL adds the multiplicand to the accumulator's upper half; DIV trial-subtracts
  // the divisor from the low WIDTH bits of the left-shifted remainder.
  always_comb begin
    add_x   = a_r;
    add_y   = b_r;
    add_sub = (op_r == OP_SUB);
    if (state == S_EXEC && op_r == OP_MUL) begin
      add_x   = acc[2*WIDTH-1:WIDTH];
      add_y   = a_r;
      add_sub = 1'b0;
    end else if (state == S_EXEC && op_r == OP_DIV) begin
      add_x   = acc[2*WIDTH-2:WIDTH-1];
      add_y   = b_r;
      add_sub = 1'b1;
    end
  end

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .x    (add_x),
    .y    (add_y),
    .sub  (add_sub),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // The shifted-out remainder MSB means the trial difference cannot borrow.
  always_comb begin
    acc_next = acc;
    if (op_r == OP_MUL) begin
      if (acc[0])
        acc_next = {add_cout, add_sum, acc[WIDTH-1:1]};
      else
        acc_next = {1'b0, acc[2*WIDTH-1:1]};
    end else if (op_r == OP_DIV) begin
      if (acc[2*WIDTH-1] | add_cout)
        acc_next = {add_sum, acc[WIDTH-2:0], 1'b1};
      else
        acc_next = {acc[2*WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    simple_result = '0;
    simple_carry  = 1'b0;
    simple_dbz    = 1'b0;
    simple_ill    = 1'b0;
    case (op_r)
      OP_ADD, OP_SUB: begin
        simple_result = {{WIDTH{1'b0}}, add_sum};
        simple_carry  = add_cout;
      end
      OP_OR:  simple_result = {{WIDTH{1'b0}}, a_r | b_r};
      OP_NOR: simple_result = {{WIDTH{1'b0}}, ~(a_r | b_r)};
      OP_DIV: begin
        simple_result = {a_r, {WIDTH{1'b1}}};
        simple_dbz    = 1'b1;
      end
      default: simple_ill = is_illegal_op(op_r);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      op_r        <= '0;
      a_r         <= '0;
      b_r         <= '0;
      acc         <= '0;
      step        <= '0;
      result      <= '0;
      carry       <= 1'b0;
      div_by_zero <= 1'b0;
      illegal_op  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_r  <= op;
            a_r   <= a;
            b_r   <= b;
            acc   <= (op == OP_DIV) ? {{WIDTH{1'b0}}, a} : {{WIDTH{1'b0}}, b};
            step  <= '0;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (iterative) begin
            acc  <= acc_next;
            step <= step + CW'(1);
            if (last_step) begin
              result      <= acc_next;
              carry       <= 1'b0;
              div_by_zero <= 1'b0;
              illegal_op  <= 1'b0;
              state       <= S_DONE;
            end
          end else begin
            result      <= simple_result;
            carry       <= simple_carry;
            div_by_zero <= simple_dbz;
            illegal_op  <= simple_ill;
            state       <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomised and directed bench for alu_op_sequencer against an arithmetic reference model.
module tb_alu_op_sequencer;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [2:0]     op = '0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2*W-1:0] result;
  logic           carry, div_by_zero, illegal_op, busy;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op          (op),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .carry       (carry),
    .div_by_zero (div_by_zero),
    .illegal_op  (illegal_op),
    .busy        (busy)
  );

  // Reference model straight from the arithmetic definitions.
  function automatic void ref_model(input logic [2:0] fop, input logic [W-1:0] fa, input logic [W-1:0] fb,
                                    output logic [2*W-1:0] r, output logic c, output logic d,
                                    output logic il, output int lat);
    int ia = int'(fa);
    int ib = int'(fb);
    r = '0; c = 1'b0; d = 1'b0; il = 1'b0; lat = 1;
    case (fop)
      3'd0: begin r = 16'((ia + ib) % 256); c = (ia + ib) > 255; end
      3'd1: begin r = 16'((ia - ib + 256) % 256); c = (ia >= ib); end
      3'd2: r = 16'(ia | ib);
      3'd3: r = 16'((~(ia | ib)) & 255);
      3'd4: begin r = 16'(ia * ib); lat = W; end
      3'd5: begin
        if (ib == 0) begin r = 16'(ia * 256 + 255); d = 1'b1; end
        else begin r = 16'((ia % ib) * 256 + ia / ib); lat = W; end
      end
      default: il = 1'b1;
    endcase
  endfunction

  // Issues one request and waits (bounded) for out_valid; does not complete the handshake.
  task automatic issue_op(input logic [2:0] iop, input logic [W-1:0] ia, input logic [W-1:0] ib,
                          output int lat, output bit ready_seen);
    int wait_cycles = 0;
    while (!in_ready && wait_cycles < 20) begin
      @(posedge clk); #1;
      wait_cycles++;
    end
    in_valid = 1'b1; op = iop; a = ia; b = ib;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 3'($urandom_range(0, 7)); a = W'($urandom); b = W'($urandom);
    lat = 0; ready_seen = 0;
    while (!out_valid && lat < 40) begin
      if (in_ready) ready_seen = 1;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic complete_op();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    tests_run++;
    if ({out_valid, busy, carry, div_by_zero, illegal_op} !== 5'b0 || result !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: out_valid=%0b busy=%0b flags=%0b%0b%0b result=%h, required all 0",
               out_valid, busy, carry, div_by_zero, illegal_op, result);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_in_ready: got %0b, required 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [2:0]   vop[10] = '{3'd0, 3'd1, 3'd1, 3'd4, 3'd5, 3'd5, 3'd2, 3'd3, 3'd7, 3'd6};
    logic [W-1:0] va[10]  = '{8'd200, 8'd5, 8'd7, 8'd255, 8'd200, 8'd13, 8'hA5, 8'hA5, 8'd9, 8'd1};
    logic [W-1:0] vb[10]  = '{8'd100, 8'd7, 8'd5, 8'd255, 8'd7, 8'd0, 8'h0F, 8'h0F, 8'd9, 8'd1};
    logic [2*W-1:0] er; logic ec, ed, ei; int elat, lat; bit rs;
    for (int i = 0; i < 10; i++) begin
      ref_model(vop[i], va[i], vb[i], er, ec, ed, ei, elat);
      issue_op(vop[i], va[i], vb[i], lat, rs);
      tests_run++;
      if (lat !== elat || rs || result !== er || {carry, div_by_zero, illegal_op} !== {ec, ed, ei}) begin
        tests_failed++;
        $display("[TB] FAIL directed_%0d op=%0d a=%0d b=%0d: lat=%0d in_ready_seen=%0b result=%h cdi=%b%b%b, required lat=%0d in_ready_seen=0 result=%h cdi=%b%b%b",
                 i, vop[i], va[i], vb[i], lat, rs, result, carry, div_by_zero, illegal_op, elat, er, ec, ed, ei);
      end
      complete_op();
    end
  endtask

  task automatic test_backpressure();
    int lat; bit rs;
    issue_op(3'd0, 8'd1, 8'd1, lat, rs);
    for (int i = 0; i < 3; i++) begin
      in_valid = (i == 1); op = 3'd0; a = 8'd9; b = 8'd9;
      @(posedge clk); #1;
      tests_run++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 16'h0002) begin
        tests_failed++;
        $display("[TB] FAIL backpressure_hold_%0d: out_valid=%0b in_ready=%0b result=%h, required 1 0 0002",
                 i, out_valid, in_ready, result);
      end
    end
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL backpressure_release: out_valid=%0b busy=%0b in_ready=%0b, required 0 0 1",
               out_valid, busy, in_ready);
    end
  endtask

  task automatic test_reset_mid_mul();
    int seen = 0; int lat; bit rs;
    in_valid = 1'b1; op = 3'd4; a = 8'd255; b = 8'd255;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({out_valid, busy, carry, div_by_zero, illegal_op} !== 5'b0 || result !== '0) begin
      tests_failed++;
      $display("[TB] FAIL mid_mul_reset: out_valid=%0b busy=%0b result=%h, required 0 0 0000",
               out_valid, busy, result);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    tests_run++;
    if (seen != 0) begin
      tests_failed++;
      $display("[TB] FAIL mid_mul_no_result: out_valid seen %0d cycles, required 0", seen);
    end
    issue_op(3'd0, 8'd3, 8'd4, lat, rs);
    tests_run++;
    if (result !== 16'h0007 || lat != 1) begin
      tests_failed++;
      $display("[TB] FAIL post_reset_add: result=%h lat=%0d, required 0007 lat=1", result, lat);
    end
    complete_op();
  endtask

  task automatic test_random();
    logic [2:0] rop; logic [W-1:0] ra, rb;
    logic [2*W-1:0] er; logic ec, ed, ei; int elat, lat, hold; bit rs;
    for (int n = 0; n < 40; n++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = W'($urandom);
      rb  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      ref_model(rop, ra, rb, er, ec, ed, ei, elat);
      issue_op(rop, ra, rb, lat, rs);
      hold = $urandom_range(0, 2);
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
      end
      tests_run++;
      if (lat !== elat || rs || out_valid !== 1'b1 || result !== er ||
          {carry, div_by_zero, illegal_op} !== {ec, ed, ei}) begin
        tests_failed++;
        $display("[TB] FAIL random_%0d op=%0d a=%0d b=%0d: lat=%0d valid=%0b result=%h cdi=%b%b%b, required lat=%0d valid=1 result=%h cdi=%b%b%b",
                 n, rop, ra, rb, lat, out_valid, result, carry, div_by_zero, illegal_op, elat, er, ec, ed, ei);
      end
      complete_op();
      tests_run++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL random_%0d_handshake: out_valid=%0b in_ready=%0b, required 0 1",
                 n, out_valid, in_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_mul();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
